// File: rtl/ppu_nmi_generator.sv
`default_nettype none
// ============================================================================
// Module   : ppu_nmi_generator
// Purpose  : Source end of the vblank NMI path. Runs the PPU dot/scanline
//            counters, owns the PPUSTATUS flags (vblank, sprite-0 hit,
//            sprite overflow) and PPUCTRL.NMI_EN, serves CPU reads of $2002,
//            and emits a one-clk NMI request on ppu_status_nmi[7].
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1   system clock
//   rst            in   1   asynchronous, active-low reset
//   dot_ce         in   1   PPU dot clock enable; counters advance when high
//   cpu_addr       in  16   CPU bus address ($2000-$3FFF, mirrored every 8)
//   cpu_data_in    in   8   CPU write data (only bit 7 of $2000 is used)
//   cpu_write_en   in   1   CPU write strobe, one clk
//   cpu_read_en    in   1   CPU read strobe, one clk
//   spr0_hit_in    in   1   renderer sprite-0 hit event (sticky-set)
//   spr_ovf_in     in   1   renderer sprite overflow event (sticky-set)
//   rendering_en   in   1   PPUMASK bg|spr enabled (odd-frame skip only)
//   reg_data_out   out  8   $2002 read data {vblank, spr0, ovf, 5'b0}
//   ppu_status_nmi out  8   bit 7 = one-clk NMI request pulse, bits 6:0 = 0
//   w_toggle_clr   out  1   one-clk pulse on a $2002 read
//   dot            out  9   current dot, 0..DOTS_PER_LINE-1
//   scanline       out  9   current scanline, 0..LINES_PER_FRAME-1
//   frame_odd      out  1   toggles on every frame wrap
// ----------------------------------------------------------------------------
// Build option
//   ODD_FRAME_SKIP_EN : when defined, an odd frame with rendering enabled
//                       skips the last dot of the pre-render line.
// ============================================================================
module ppu_nmi_generator #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dot_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  input  logic        spr0_hit_in,
  input  logic        spr_ovf_in,
  input  logic        rendering_en,
  output logic [7:0]  reg_data_out,
  output logic [7:0]  ppu_status_nmi,
  output logic        w_toggle_clr,
  output logic [8:0]  dot,
  output logic [8:0]  scanline,
  output logic        frame_odd
);

  // --------------------------------------------------------------------------
  // Counter landmarks
  // --------------------------------------------------------------------------
  localparam logic [8:0] c_dot_last  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] c_line_last = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] c_vbl_line  = 9'(VBLANK_LINE);
  localparam logic [8:0] c_pre_line  = 9'(PRERENDER_LINE);
  // Flag events happen on dot 1 of their scanline.
  localparam logic [8:0] c_flag_dot  = 9'd1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [8:0] r_dot;
  logic [8:0] r_line;
  logic       r_frame_odd;
  logic       r_vblank;
  logic       r_spr0;
  logic       r_ovf;
  logic       r_nmi_en;
  logic       r_nmi_req;    // registered vblank & nmi_en (edge reference)
  logic       r_nmi_pulse;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic       w_reg_sel;
  logic       w_wr_ctrl;
  logic       w_rd_status;
  logic       w_skip;
  logic       w_frame_end;
  logic       w_vbl_set;
  logic       w_pre_clr;
  logic [8:0] w_dot_nxt;
  logic [8:0] w_line_nxt;
  logic       w_odd_nxt;
  logic       w_vblank_nxt;
  logic       w_spr0_nxt;
  logic       w_ovf_nxt;
  logic       w_nmi_en_nxt;
  logic       w_nmi_req_nxt;
  logic       w_unused_ok;

  // --------------------------------------------------------------------------
  // CPU bus decode: $2000-$3FFF, register index in the low three bits
  // --------------------------------------------------------------------------
  assign w_reg_sel   = (cpu_addr[15:13] == 3'b001);
  assign w_wr_ctrl   = w_reg_sel & cpu_write_en & (cpu_addr[2:0] == 3'd0);
  assign w_rd_status = w_reg_sel & cpu_read_en  & (cpu_addr[2:0] == 3'd2);

  // --------------------------------------------------------------------------
  // Odd-frame dot skip
  // --------------------------------------------------------------------------
`ifdef ODD_FRAME_SKIP_EN
  // Jump from (pre-render, last-1) straight to (0,0) on odd rendered frames.
  assign w_skip      = r_frame_odd & rendering_en &
                       (r_line == c_pre_line) &
                       (r_dot  == 9'(DOTS_PER_LINE - 2));
  assign w_unused_ok = ^{cpu_addr[12:3], cpu_data_in[6:0]};
`else
  assign w_skip      = 1'b0;
  assign w_unused_ok = ^{cpu_addr[12:3], cpu_data_in[6:0], rendering_en};
`endif

  assign w_frame_end = w_skip | ((r_dot == c_dot_last) & (r_line == c_line_last));

  // --------------------------------------------------------------------------
  // Dot / scanline / frame parity next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_dot_nxt  = r_dot;
    w_line_nxt = r_line;
    w_odd_nxt  = r_frame_odd;
    if (dot_ce) begin
      if (w_frame_end) begin
        w_dot_nxt  = 9'd0;
        w_line_nxt = 9'd0;
        w_odd_nxt  = ~r_frame_odd;
      end else if (r_dot == c_dot_last) begin
        w_dot_nxt  = 9'd0;
        w_line_nxt = r_line + 9'd1;
      end else begin
        w_dot_nxt  = r_dot + 9'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status flags next state
  // --------------------------------------------------------------------------
  assign w_vbl_set = dot_ce & (r_line == c_vbl_line) & (r_dot == c_flag_dot);
  assign w_pre_clr = dot_ce & (r_line == c_pre_line) & (r_dot == c_flag_dot);

  // Later assignments take priority: a $2002 read in the vblank-set clk
  // suppresses the set for the whole frame, and the pre-render clear beats
  // everything.
  always_comb begin
    w_vblank_nxt = r_vblank;
    if (w_vbl_set) begin
      w_vblank_nxt = 1'b1;
    end
    if (w_rd_status) begin
      w_vblank_nxt = 1'b0;
    end
    if (w_pre_clr) begin
      w_vblank_nxt = 1'b0;
    end
  end

  // Sprite events are sticky on any clk; the pre-render clear wins.
  always_comb begin
    w_spr0_nxt = r_spr0 | spr0_hit_in;
    w_ovf_nxt  = r_ovf  | spr_ovf_in;
    if (w_pre_clr) begin
      w_spr0_nxt = 1'b0;
      w_ovf_nxt  = 1'b0;
    end
  end

  assign w_nmi_en_nxt  = w_wr_ctrl ? cpu_data_in[7] : r_nmi_en;

  // The request is evaluated on next-state values so the pulse appears in
  // the clk right after the vblank-set (or enabling write) clk. A falling
  // request, e.g. from a $2002 read, can never produce a pulse.
  assign w_nmi_req_nxt = w_vblank_nxt & w_nmi_en_nxt;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dot       <= 9'd0;
      r_line      <= 9'd0;
      r_frame_odd <= 1'b0;
      r_vblank    <= 1'b0;
      r_spr0      <= 1'b0;
      r_ovf       <= 1'b0;
      r_nmi_en    <= 1'b0;
      r_nmi_req   <= 1'b0;
      r_nmi_pulse <= 1'b0;
    end else begin
      r_dot       <= w_dot_nxt;
      r_line      <= w_line_nxt;
      r_frame_odd <= w_odd_nxt;
      r_vblank    <= w_vblank_nxt;
      r_spr0      <= w_spr0_nxt;
      r_ovf       <= w_ovf_nxt;
      r_nmi_en    <= w_nmi_en_nxt;
      r_nmi_req   <= w_nmi_req_nxt;
      r_nmi_pulse <= w_nmi_req_nxt & ~r_nmi_req;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign reg_data_out   = {r_vblank, r_spr0, r_ovf, 5'b00000};
  assign ppu_status_nmi = {r_nmi_pulse, 7'b0000000};
  // Held low while reset is asserted so every output reads 0 in reset.
  assign w_toggle_clr   = w_rd_status & rst;
  assign dot            = r_dot;
  assign scanline       = r_line;
  assign frame_odd      = r_frame_odd;

endmodule
`default_nettype wire

// File: tb/tb_ppu_nmi_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_nmi_generator
// Purpose  : Self-checking bench for ppu_nmi_generator, run with a shrunken
//            frame (20 dots x 12 lines) so several frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_nmi_generator;

  localparam int D     = 20;
  localparam int L     = 12;
  localparam int VB    = 9;
  localparam int PR    = 11;
  localparam int FRAME = D * L;
`ifdef ODD_FRAME_SKIP_EN
  localparam int ODD_LEN = FRAME - 1;
`else
  localparam int ODD_LEN = FRAME;
`endif

  logic        clk          = 1'b0;
  logic        rst          = 1'b0;
  logic        dot_ce       = 1'b0;
  logic [15:0] cpu_addr     = 16'h0000;
  logic [7:0]  cpu_data_in  = 8'h00;
  logic        cpu_write_en = 1'b0;
  logic        cpu_read_en  = 1'b0;
  logic        spr0_hit_in  = 1'b0;
  logic        spr_ovf_in   = 1'b0;
  logic        rendering_en = 1'b0;
  logic [7:0]  reg_data_out;
  logic [7:0]  ppu_status_nmi;
  logic        w_toggle_clr;
  logic [8:0]  dot;
  logic [8:0]  scanline;
  logic        frame_odd;

  ppu_nmi_generator #(
    .DOTS_PER_LINE  (D),
    .LINES_PER_FRAME(L),
    .VBLANK_LINE    (VB),
    .PRERENDER_LINE (PR)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .dot_ce        (dot_ce),
    .cpu_addr      (cpu_addr),
    .cpu_data_in   (cpu_data_in),
    .cpu_write_en  (cpu_write_en),
    .cpu_read_en   (cpu_read_en),
    .spr0_hit_in   (spr0_hit_in),
    .spr_ovf_in    (spr_ovf_in),
    .rendering_en  (rendering_en),
    .reg_data_out  (reg_data_out),
    .ppu_status_nmi(ppu_status_nmi),
    .w_toggle_clr  (w_toggle_clr),
    .dot           (dot),
    .scanline      (scanline),
    .frame_odd     (frame_odd)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int mon_e = 0;
  int q_nmi[$];   // cycle numbers in which an NMI pulse is expected

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // NMI scoreboard: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (q_nmi.size() > 0 && q_nmi[0] < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL nmi_missing: got no pulse expected pulse in cycle %0d", q_nmi[0]);
      void'(q_nmi.pop_front());
    end
    if (ppu_status_nmi !== 8'h00) begin
      n_vec++;
      if (q_nmi.size() == 0) begin
        n_err++;
        $display("FAIL nmi_unexpected: got %h in cycle %0d expected no pulse", ppu_status_nmi, cyc);
      end else begin
        mon_e = q_nmi.pop_front();
        if (mon_e != cyc || ppu_status_nmi !== 8'h80) begin
          n_err++;
          $display("FAIL nmi_pulse: got %h in cycle %0d expected 80 in cycle %0d",
                   ppu_status_nmi, cyc, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_addr     = 16'h0000;
    cpu_data_in  = 8'h00;
    cpu_write_en = 1'b0;
    cpu_read_en  = 1'b0;
    spr0_hit_in  = 1'b0;
    spr_ovf_in   = 1'b0;
  endtask

  // One bus clk: drive, check combinational outputs mid-cycle, advance.
  task automatic bus(input string nm, input logic [15:0] a, input logic [7:0] wd,
                     input logic wr, input logic rd, input logic hit, input logic ovf,
                     input logic chk_d, input logic [7:0] exp_d, input logic exp_t);
    cpu_addr     = a;
    cpu_data_in  = wd;
    cpu_write_en = wr;
    cpu_read_en  = rd;
    spr0_hit_in  = hit;
    spr_ovf_in   = ovf;
    @(negedge clk);
    if (chk_d) chk({nm, "_data"}, 16'(reg_data_out), 16'(exp_d));
    chk({nm, "_toggle"}, 16'(w_toggle_clr), 16'(exp_t));
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd2002(input string nm, input logic [7:0] exp_d);
    bus(nm, 16'h2002, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_d, 1'b1);
  endtask

  task automatic wr2000(input string nm, input logic [7:0] wd);
    bus(nm, 16'h2000, wd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic go_to(input int l, input int d);
    int n;
    n = 0;
    while (!(int'(scanline) == l && int'(dot) == d)) begin
      tick();
      n++;
      if (n > 2 * FRAME) begin
        n_vec++;
        n_err++;
        $display("FAIL go_to_timeout: got (%0d,%0d) expected (%0d,%0d)", scanline, dot, l, d);
        return;
      end
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  wd;
    logic        wr;
    logic        rd;
    logic        hit;
    logic        ovf;
    logic        chk_d;
    logic [7:0]  exp_d;
    logic        exp_t;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    //              addr      wdata  wr    rd    hit   ovf   chk   exp    tog
    tbl[0]  = '{16'h2002, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[1]  = '{16'h2000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{16'h2002, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1};
    tbl[3]  = '{16'h3FFA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1};
    tbl[4]  = '{16'h2002, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 1'b1};
    tbl[5]  = '{16'h2003, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{16'h4002, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{16'h2000, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{16'h2002, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{16'h200A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 1'b1};
    tbl[10] = '{16'h0002, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    // Reset state, with a $2002 read attempted during reset.
    cpu_addr    = 16'h2002;
    cpu_read_en = 1'b1;
    tick();
    tick();
    chk("rst_dot",      16'(dot),            16'd0);
    chk("rst_scanline", 16'(scanline),       16'd0);
    chk("rst_odd",      16'(frame_odd),      16'd0);
    chk("rst_data",     16'(reg_data_out),   16'h00);
    chk("rst_nmi",      16'(ppu_status_nmi), 16'h00);
    chk("rst_toggle",   16'(w_toggle_clr),   16'd0);
    idle();
    rst = 1'b1;

    // Counters hold without dot_ce, then advance 45 dots.
    for (int i = 0; i < 3; i++) tick();
    chk("hold_dot", 16'(dot), 16'd0);
    dot_ce = 1'b1;
    for (int i = 0; i < 45; i++) tick();
    chk("cnt_dot",      16'(dot),      16'd5);
    chk("cnt_scanline", 16'(scanline), 16'd2);

    // Frame 0: decode / flag table.
    foreach (tbl[i])
      bus($sformatf("tbl%0d", i), tbl[i].a, tbl[i].wd, tbl[i].wr, tbl[i].rd,
          tbl[i].hit, tbl[i].ovf, tbl[i].chk_d, tbl[i].exp_d, tbl[i].exp_t);

    // Frame 0: vblank passes with nmi_en=0; enabling later gives a pulse,
    // and 0 then 1 gives a second one.
    go_to(VB + 1, 0);
    q_nmi.push_back(cyc + 1);
    wr2000("en_late", 8'h80);
    wr2000("dis", 8'h00);
    q_nmi.push_back(cyc + 1);
    wr2000("reen", 8'h80);
    go_to(PR, 1);
    rd2002("pre_rd_race", 8'hE0);
    rd2002("pre_after", 8'h00);

    // Frame 1: normal vblank NMI, read clears vblank.
    go_to(VB, 1);
    q_nmi.push_back(cyc + 1);
    go_to(VB, 5);
    rd2002("vbl_rd1", 8'h80);
    rd2002("vbl_rd2", 8'h00);

    // Frame 2: sprite events, then a read on the vblank-set clk.
    go_to(3, 5);
    bus("hit", 16'h2000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    go_to(4, 2);
    bus("ovf", 16'h2000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    go_to(5, 0);
    rd2002("spr_rd", 8'h60);
    go_to(VB, 1);
    rd2002("race_rd", 8'h60);
    go_to(VB, 3);
    rd2002("race_after", 8'h60);
    go_to(PR, 1);
    rd2002("pre_rd", 8'h60);
    rd2002("pre_clr", 8'h00);

    // Frame 3: NMI again; sprite events on the clear dot lose.
    go_to(VB, 1);
    q_nmi.push_back(cyc + 1);
    go_to(PR, 1);
    bus("clr_win", 16'h2002, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1);
    rd2002("clr_win_after", 8'h00);
    wr2000("nmi_off", 8'h00);

    // Frame 4 passes vblank with nmi_en=0; mid-frame reset in frame 5.
    go_to(VB, 5);
    go_to(5, 2);
    bus("hit5", 16'h2000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    rd2002("pre_reset", 8'h40);
    chk("odd_before_reset", 16'(frame_odd), 16'd1);
    rst = 1'b0;
    #2;
    chk("mrst_dot",      16'(dot),            16'd0);
    chk("mrst_scanline", 16'(scanline),       16'd0);
    chk("mrst_odd",      16'(frame_odd),      16'd0);
    chk("mrst_data",     16'(reg_data_out),   16'h00);
    chk("mrst_nmi",      16'(ppu_status_nmi), 16'h00);
    tick();
    tick();
    rst          = 1'b1;
    rendering_en = 1'b1;

    // Frame lengths after reset (nmi_en is 0 again: no pulses).
    n = 0;
    while (frame_odd !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("even_frame_len", 16'(n), 16'(FRAME));
    n = 0;
    while (frame_odd !== 1'b0 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("odd_frame_len", 16'(n), 16'(ODD_LEN));

    for (int i = 0; i < 4; i++) tick();
    while (q_nmi.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL nmi_never_seen: got no pulse expected pulse in cycle %0d", q_nmi.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
